// File: rtl/pgm_wr.sv
// pgm_wr: template writer and generation controller for the packet generator.
// Captures one template packet into the 128x144 PGM RAM, passes live traffic
// while idle, and drives the bypass/start/finish levels used by the read side.
// Optional feature macro: PGM_WR_DURATION_EN (gen_cycles countdown auto-finish).
//
// state   | meaning
// IDLE    | bypass, forward live traffic, wait for an armed head flit
// CAPTURE | write template flits into PGM RAM
// READY   | template stored, drop traffic, wait for start
// RUN     | read side generating, drop and count traffic
// FIN     | read side stops after its current packet

module pgm_wr #(
  parameter string      PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd61,
  parameter logic [7:0] NMID     = 8'd62
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic [1023:0]   in_wr_phv,
  input  logic            in_wr_phv_wr,
  output logic            out_wr_phv_alf,
  input  logic [133:0]    in_wr_data,
  input  logic            in_wr_data_wr,
  input  logic            in_wr_valid,
  input  logic            in_wr_valid_wr,
  output logic            out_wr_alf,

  output logic [1023:0]   out_wr_phv,
  output logic            out_wr_phv_wr,
  input  logic            in_wr_phv_alf,
  output logic [133:0]    out_wr_data,
  output logic            out_wr_data_wr,
  output logic            out_wr_valid,
  output logic            out_wr_valid_wr,
  input  logic            in_wr_alf,

  output logic            wr2ram_wr,
  output logic [6:0]      wr2ram_addr,
  output logic [143:0]    wr2ram_wdata,

  output logic            pgm_bypass_flag,
  output logic            pgm_sent_start_flag,
  output logic            pgm_sent_finish_flag,

  input  logic [133:0]    cin_wr_data,
  input  logic            cin_wr_data_wr,
  output logic            cout_wr_ready,
  output logic [133:0]    cout_wr_data,
  output logic            cout_wr_data_wr,
  input  logic            cin_wr_ready
);

  // One-hot encoding so the state register doubles as the register-7 readout.
  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_CAPTURE = 5'b00010;
  localparam logic [4:0] S_READY   = 5'b00100;
  localparam logic [4:0] S_RUN     = 5'b01000;
  localparam logic [4:0] S_FIN     = 5'b10000;

  logic [4:0]  state;
  logic        capture_arm;
  logic [6:0]  wr_ptr;
  logic [7:0]  tpl_len;
  logic        ovf;
  logic        ovf_drop;
  logic [31:0] drop_cnt;
`ifdef PGM_WR_DURATION_EN
  logic [31:0] gen_cycles;
  logic [31:0] dur_cnt;
`endif

  logic        flit_hd;
  logic        flit_tl;
  logic        cap_start;
  logic        fwd_en;
  logic        cfg_hit;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        wr_soft;
  logic        wr_arm;
  logic        wr_start;
  logic        wr_stop;
`ifdef PGM_WR_DURATION_EN
  logic        wr_gen;
`endif
  logic [31:0] rd_val;

  assign out_wr_phv_alf = in_wr_phv_alf;
  assign out_wr_alf     = in_wr_alf;
  assign cout_wr_ready  = cin_wr_ready;

  assign pgm_bypass_flag      = state[0];
  assign pgm_sent_start_flag  = state[3];
  assign pgm_sent_finish_flag = state[4];

  assign flit_hd   = in_wr_data_wr && (in_wr_data[133:132] == 2'b01);
  assign flit_tl   = in_wr_data_wr && (in_wr_data[133:132] == 2'b10);
  // The head that opens a capture goes to RAM, not downstream.
  assign cap_start = (state == S_IDLE) && capture_arm && flit_hd;
  assign fwd_en    = (state == S_IDLE) && !cap_start;

  assign cfg_hit   = cin_wr_data_wr && (cin_wr_data[133:132] == 2'b01) &&
                     (cin_wr_data[103:96] == LMID);
  assign cfg_wr    = cfg_hit && (cin_wr_data[126:124] == 3'b010);
  assign cfg_rd    = cfg_hit && (cin_wr_data[126:124] == 3'b001);
  assign cfg_addr  = cin_wr_data[95:64];
  assign cfg_wdata = cin_wr_data[31:0];
  assign wr_soft   = cfg_wr && (cfg_addr == 32'd0) && cfg_wdata[0];
  assign wr_arm    = cfg_wr && (cfg_addr == 32'd1);
  assign wr_start  = cfg_wr && (cfg_addr == 32'd2);
  assign wr_stop   = cfg_wr && (cfg_addr == 32'd3);
`ifdef PGM_WR_DURATION_EN
  assign wr_gen    = cfg_wr && (cfg_addr == 32'd4);
`endif

  // Register read mux for cfg read responses.
  always_comb begin
    rd_val = 32'hFFFF_FFFF;
    case (cfg_addr)
      32'd0:        rd_val = 32'd0;
      32'd1:        rd_val = {31'd0, capture_arm};
      32'd2, 32'd3: rd_val = 32'd0;
`ifdef PGM_WR_DURATION_EN
      32'd4:        rd_val = gen_cycles;
`endif
      32'd5:        rd_val = {23'd0, ovf, tpl_len};
      32'd6:        rd_val = drop_cnt;
      32'd7:        rd_val = {27'd0, state};
      default:      rd_val = 32'hFFFF_FFFF;
    endcase
  end

  // Data/valid/PHV forwarding with one cycle of latency, only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_data     <= '0;
      out_wr_data_wr  <= 1'b0;
      out_wr_valid    <= 1'b0;
      out_wr_valid_wr <= 1'b0;
      out_wr_phv      <= '0;
      out_wr_phv_wr   <= 1'b0;
    end else begin
      out_wr_data     <= in_wr_data;
      out_wr_data_wr  <= in_wr_data_wr && fwd_en;
      out_wr_valid    <= in_wr_valid;
      out_wr_valid_wr <= in_wr_valid_wr && fwd_en;
      out_wr_phv      <= in_wr_phv;
      out_wr_phv_wr   <= in_wr_phv_wr && fwd_en;
    end
  end

  // Cfg chain: pass through, or turn a local read into a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_wr_data    <= '0;
      cout_wr_data_wr <= 1'b0;
    end else begin
      cout_wr_data_wr <= cin_wr_data_wr;
      if (cfg_rd)
        cout_wr_data <= {cin_wr_data[133:128], 4'b1011, cin_wr_data[123:32], rd_val};
      else
        cout_wr_data <= cin_wr_data;
    end
  end

`ifdef PGM_WR_DURATION_EN
  // gen_cycles survives soft reset, so it lives outside the FSM block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gen_cycles <= 32'd0;
    else if (wr_gen)
      gen_cycles <= cfg_wdata;
  end
`endif

  // Main FSM, template RAM writes and the status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      capture_arm  <= 1'b0;
      wr_ptr       <= 7'd0;
      tpl_len      <= 8'd0;
      ovf          <= 1'b0;
      ovf_drop     <= 1'b0;
      drop_cnt     <= 32'd0;
      wr2ram_wr    <= 1'b0;
      wr2ram_addr  <= 7'd0;
      wr2ram_wdata <= '0;
`ifdef PGM_WR_DURATION_EN
      dur_cnt      <= 32'd0;
`endif
    end else begin
      wr2ram_wr <= 1'b0;
      if (wr_soft) begin
        state       <= S_IDLE;
        capture_arm <= 1'b0;
        wr_ptr      <= 7'd0;
        tpl_len     <= 8'd0;
        ovf         <= 1'b0;
        ovf_drop    <= 1'b0;
        drop_cnt    <= 32'd0;
`ifdef PGM_WR_DURATION_EN
        dur_cnt     <= 32'd0;
`endif
      end else begin
        if (wr_arm)
          capture_arm <= cfg_wdata[0];
        if ((state == S_READY || state == S_RUN) && flit_hd &&
            drop_cnt != 32'hFFFF_FFFF)
          drop_cnt <= drop_cnt + 32'd1;

        case (state)
          S_IDLE: begin
            if (cap_start) begin
              wr2ram_wr    <= 1'b1;
              wr2ram_addr  <= 7'd0;
              wr2ram_wdata <= {10'd0, in_wr_data};
              wr_ptr       <= 7'd1;
              ovf          <= 1'b0;
              ovf_drop     <= 1'b0;
              state        <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (in_wr_data_wr) begin
              if (ovf_drop) begin
                if (flit_tl) begin
                  ovf_drop    <= 1'b0;
                  capture_arm <= 1'b0;
                  wr_ptr      <= 7'd0;
                  state       <= S_READY;
                end
              end else if (flit_tl) begin
                wr2ram_wr    <= 1'b1;
                wr2ram_addr  <= wr_ptr;
                wr2ram_wdata <= {10'd0, in_wr_data};
                tpl_len      <= {1'b0, wr_ptr} + 8'd1;
                capture_arm  <= 1'b0;
                wr_ptr       <= 7'd0;
                state        <= S_READY;
              end else if (wr_ptr == 7'd127) begin
                // RAM full: close the template with a forced tail header.
                wr2ram_wr    <= 1'b1;
                wr2ram_addr  <= wr_ptr;
                wr2ram_wdata <= {10'd0, 2'b10, in_wr_data[131:0]};
                tpl_len      <= 8'd128;
                ovf          <= 1'b1;
                ovf_drop     <= 1'b1;
              end else begin
                wr2ram_wr    <= 1'b1;
                wr2ram_addr  <= wr_ptr;
                wr2ram_wdata <= {10'd0, in_wr_data};
                wr_ptr       <= wr_ptr + 7'd1;
              end
            end
          end
          S_READY: begin
            if (wr_start) begin
`ifdef PGM_WR_DURATION_EN
              dur_cnt <= gen_cycles;
`endif
              state <= S_RUN;
            end
          end
          S_RUN: begin
`ifdef PGM_WR_DURATION_EN
            if (dur_cnt != 32'd0)
              dur_cnt <= dur_cnt - 32'd1;
            // Terminal count: the decrement from 1 is the step that reaches 0.
            if (wr_stop || (gen_cycles != 32'd0 && dur_cnt == 32'd1))
              state <= S_FIN;
`else
            if (wr_stop)
              state <= S_FIN;
`endif
          end
          S_FIN: begin
            if (wr_arm)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pgm_wr.sv
// Directed self-checking bench for pgm_wr.
module tb_pgm_wr;

  logic           clk;
  logic           rst_n;
  logic [1023:0]  in_wr_phv;
  logic           in_wr_phv_wr;
  logic           out_wr_phv_alf;
  logic [133:0]   in_wr_data;
  logic           in_wr_data_wr;
  logic           in_wr_valid;
  logic           in_wr_valid_wr;
  logic           out_wr_alf;
  logic [1023:0]  out_wr_phv;
  logic           out_wr_phv_wr;
  logic           in_wr_phv_alf;
  logic [133:0]   out_wr_data;
  logic           out_wr_data_wr;
  logic           out_wr_valid;
  logic           out_wr_valid_wr;
  logic           in_wr_alf;
  logic           wr2ram_wr;
  logic [6:0]     wr2ram_addr;
  logic [143:0]   wr2ram_wdata;
  logic           pgm_bypass_flag;
  logic           pgm_sent_start_flag;
  logic           pgm_sent_finish_flag;
  logic [133:0]   cin_wr_data;
  logic           cin_wr_data_wr;
  logic           cout_wr_ready;
  logic [133:0]   cout_wr_data;
  logic           cout_wr_data_wr;
  logic           cin_wr_ready;

  int checks = 0;
  int errors = 0;

  pgm_wr dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr), .out_wr_phv_alf(out_wr_phv_alf),
    .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
    .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr), .out_wr_alf(out_wr_alf),
    .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr), .in_wr_phv_alf(in_wr_phv_alf),
    .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
    .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr), .in_wr_alf(in_wr_alf),
    .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr), .cout_wr_ready(cout_wr_ready),
    .cout_wr_data(cout_wr_data), .cout_wr_data_wr(cout_wr_data_wr), .cin_wr_ready(cin_wr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] mkf(input logic [1:0] hdr, input logic [31:0] n);
    return {hdr, 4'hF, 32'h1111_0000 + n, 32'h2222_0000 + n,
            32'h3333_0000 + n, 32'h4444_0000 + n};
  endfunction

  function automatic logic [133:0] cfg_flit(input logic [2:0] kind, input logic [7:0] mid,
                                            input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] f;
    f = '0;
    f[133:132] = 2'b01;
    f[126:124] = kind;
    f[123:104] = 20'hABCDE;
    f[103:96]  = mid;
    f[95:64]   = addr;
    f[63:32]   = 32'h0BAD_F00D;
    f[31:0]    = data;
    return f;
  endfunction

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    cin_wr_data    = cfg_flit(3'b010, 8'd61, addr, data);
    cin_wr_data_wr = 1'b1;
    tick();
    cin_wr_data_wr = 1'b0;
  endtask

  task automatic cfg_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cin_wr_data    = cfg_flit(3'b001, 8'd61, addr, 32'h0);
    cin_wr_data_wr = 1'b1;
    tick();
    cin_wr_data_wr = 1'b0;
    chk1({tag, "_rsp_wr"}, cout_wr_data_wr, 1'b1);
    chk32({tag, "_rsp_code"}, {28'd0, cout_wr_data[127:124]}, 32'hB);
    chk32(tag, cout_wr_data[31:0], exp);
  endtask

  task automatic send(input logic [133:0] f);
    in_wr_data    = f;
    in_wr_data_wr = 1'b1;
    tick();
  endtask

  logic [1:0]   hdr3 [3];
  logic [1:0]   hdr4 [4];
  logic [133:0] f;
  logic [31:0]  n;
  logic [31:0]  nwr;
  logic [1:0]   h;

  initial begin
    hdr3 = '{2'b01, 2'b11, 2'b10};
    hdr4 = '{2'b01, 2'b11, 2'b11, 2'b10};
    rst_n = 1'b0;
    in_wr_phv = '0; in_wr_phv_wr = 1'b0; in_wr_data = '0; in_wr_data_wr = 1'b0;
    in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0; in_wr_phv_alf = 1'b0; in_wr_alf = 1'b0;
    cin_wr_data = '0; cin_wr_data_wr = 1'b0; cin_wr_ready = 1'b0;
    tick(); tick();

    // Reset values
    chk1("rst_bypass", pgm_bypass_flag, 1'b1);
    chk1("rst_start", pgm_sent_start_flag, 1'b0);
    chk1("rst_finish", pgm_sent_finish_flag, 1'b0);
    chk1("rst_out_wr", out_wr_data_wr, 1'b0);
    chk1("rst_ram_wr", wr2ram_wr, 1'b0);
    chk1("rst_cout_wr", cout_wr_data_wr, 1'b0);
    rst_n = 1'b1;
    tick();
    cfg_read("rst_state", 32'd7, 32'h1);
    cfg_read("rst_arm", 32'd1, 32'h0);
    cfg_read("rst_tpl", 32'd5, 32'h0);
`ifdef PGM_WR_DURATION_EN
    cfg_read("rst_gen", 32'd4, 32'h0);
`else
    cfg_read("rst_gen", 32'd4, 32'hFFFF_FFFF);
`endif

    // Idle passthrough with PHV on the head
    for (int i = 0; i < 3; i++) begin
      f = mkf(hdr3[i], 32'(i));
      in_wr_phv    = {32{32'hDEAD_BEEF}} ^ {1024{i[0]}};
      in_wr_phv_wr = (i == 0);
      send(f);
      chk1("pt_wr", out_wr_data_wr, 1'b1);
      chkw("pt_data", {10'd0, out_wr_data}, {10'd0, f});
      chk1("pt_ram_wr", wr2ram_wr, 1'b0);
      chk1("pt_bypass", pgm_bypass_flag, 1'b1);
      if (i == 0) begin
        chk1("pt_phv_wr", out_wr_phv_wr, 1'b1);
        chk32("pt_phv_lo", out_wr_phv[31:0], 32'hDEAD_BEEF);
        chk32("pt_phv_hi", out_wr_phv[1023:992], 32'hDEAD_BEEF);
      end
    end
    in_wr_data_wr = 1'b0;
    in_wr_phv_wr  = 1'b0;
    tick();
    chk1("pt_idle", out_wr_data_wr, 1'b0);

    // Capture a 4-flit template
    cfg_write(32'd1, 32'd1);
    cfg_read("arm_set", 32'd1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      f = mkf(hdr4[i], 32'(i + 16));
      send(f);
      chk1("cap_ram_wr", wr2ram_wr, 1'b1);
      chk32("cap_addr", {25'd0, wr2ram_addr}, 32'(i));
      chkw("cap_wdata", wr2ram_wdata, {10'd0, f});
      chk1("cap_no_fwd", out_wr_data_wr, 1'b0);
    end
    in_wr_data_wr = 1'b0;
    tick();
    chk1("cap_bypass", pgm_bypass_flag, 1'b0);
    chk1("cap_ram_idle", wr2ram_wr, 1'b0);
    cfg_read("cap_tpl", 32'd5, 32'd4);
    cfg_read("cap_state", 32'd7, 32'h4);
    cfg_read("cap_arm_clr", 32'd1, 32'h0);

    // Drop in READY, stop ignored in READY
    send(mkf(2'b01, 32'd40));
    chk1("rdy_drop_hd", out_wr_data_wr, 1'b0);
    send(mkf(2'b10, 32'd41));
    chk1("rdy_drop_tl", out_wr_data_wr, 1'b0);
    in_wr_data_wr = 1'b0;
    cfg_read("rdy_drop_cnt", 32'd6, 32'd1);
    cfg_write(32'd3, 32'd1);
    cfg_read("rdy_stop_ign", 32'd7, 32'h4);

    // Duration run, or stop-only run without the countdown
`ifdef PGM_WR_DURATION_EN
    cfg_write(32'd4, 32'd10);
    cfg_read("gen_rd", 32'd4, 32'd10);
    cfg_write(32'd2, 32'd1);
    chk1("dur_start", pgm_sent_start_flag, 1'b1);
    n = 32'd1;
    for (int k = 0; k < 30 && pgm_sent_start_flag; k++) begin
      tick();
      if (pgm_sent_start_flag) n = n + 32'd1;
    end
    chk32("dur_len", n, 32'd10);
`else
    cfg_write(32'd4, 32'd5);
    cfg_read("gen_ignored", 32'd4, 32'hFFFF_FFFF);
    cfg_write(32'd2, 32'd1);
    chk1("run_start", pgm_sent_start_flag, 1'b1);
    repeat (15) tick();
    chk1("run_hold", pgm_sent_start_flag, 1'b1);
    chk1("run_no_fin", pgm_sent_finish_flag, 1'b0);
    cfg_write(32'd3, 32'd1);
`endif
    chk1("fin_flag", pgm_sent_finish_flag, 1'b1);
    chk1("fin_start_clr", pgm_sent_start_flag, 1'b0);
    cfg_read("fin_state", 32'd7, 32'h10);
    cfg_write(32'd2, 32'd1);
    chk1("fin_start_ign", pgm_sent_start_flag, 1'b0);
    cfg_read("fin_state2", 32'd7, 32'h10);

    // Soft reset from FIN
    cfg_write(32'd0, 32'd1);
    chk1("srst_bypass", pgm_bypass_flag, 1'b1);
    chk1("srst_finish", pgm_sent_finish_flag, 1'b0);
    cfg_read("srst_state", 32'd7, 32'h1);
    cfg_read("srst_tpl", 32'd5, 32'h0);
    cfg_read("srst_drop", 32'd6, 32'h0);
    cfg_read("srst_self_clr", 32'd0, 32'h0);
`ifdef PGM_WR_DURATION_EN
    cfg_read("srst_gen_kept", 32'd4, 32'd10);
`endif

    // Overflow: 130-flit packet
    cfg_write(32'd1, 32'd1);
    nwr = 32'd0;
    for (int i = 0; i < 130; i++) begin
      h = (i == 0) ? 2'b01 : ((i == 129) ? 2'b10 : 2'b11);
      f = mkf(h, 32'(i + 100));
      send(f);
      if (wr2ram_wr) nwr = nwr + 32'd1;
      if (i == 0) chk32("ovf_addr0", {25'd0, wr2ram_addr}, 32'd0);
      if (i == 126) chkw("ovf_wd126", wr2ram_wdata, {10'd0, f});
      if (i == 127) begin
        chk32("ovf_addr127", {25'd0, wr2ram_addr}, 32'd127);
        chkw("ovf_forced_tail", wr2ram_wdata, {10'd0, 2'b10, f[131:0]});
      end
      if (i == 128) chk1("ovf_drop_wr", wr2ram_wr, 1'b0);
    end
    in_wr_data_wr = 1'b0;
    tick();
    chk32("ovf_nwr", nwr, 32'd128);
    cfg_read("ovf_reg5", 32'd5, 32'h180);
    cfg_read("ovf_state", 32'd7, 32'h4);
    cfg_read("ovf_drop_cnt", 32'd6, 32'h0);

    // Stop-terminated run with dropped packets
`ifdef PGM_WR_DURATION_EN
    cfg_write(32'd4, 32'd0);
`endif
    cfg_write(32'd2, 32'd1);
    chk1("stop_run", pgm_sent_start_flag, 1'b1);
    for (int p = 0; p < 2; p++) begin
      send(mkf(2'b01, 32'(200 + p)));
      chk1("run_drop_hd", out_wr_data_wr, 1'b0);
      send(mkf(2'b10, 32'(210 + p)));
      chk1("run_drop_tl", out_wr_data_wr, 1'b0);
    end
    in_wr_data_wr = 1'b0;
    repeat (5) tick();
    chk1("stop_run_hold", pgm_sent_start_flag, 1'b1);
    cfg_write(32'd3, 32'd1);
    chk1("stop_fin", pgm_sent_finish_flag, 1'b1);
    chk1("stop_start_clr", pgm_sent_start_flag, 1'b0);
    cfg_read("stop_drop_cnt", 32'd6, 32'd2);
    cfg_write(32'd2, 32'd1);
    cfg_read("stop_start_ign", 32'd7, 32'h10);
    cfg_write(32'd1, 32'd0);
    chk1("rearm_bypass", pgm_bypass_flag, 1'b1);
    chk1("rearm_finish", pgm_sent_finish_flag, 1'b0);

    // Cfg read of an unknown address and a foreign-MID flit
    f = cfg_flit(3'b001, 8'd61, 32'd9, 32'h1234_5678);
    cin_wr_data = f; cin_wr_data_wr = 1'b1;
    tick();
    cin_wr_data_wr = 1'b0;
    chk1("unk_wr", cout_wr_data_wr, 1'b1);
    chk32("unk_code", {28'd0, cout_wr_data[127:124]}, 32'hB);
    chk32("unk_val", cout_wr_data[31:0], 32'hFFFF_FFFF);
    chkw("unk_rest", {42'd0, cout_wr_data[133:128], cout_wr_data[123:32]},
                     {42'd0, f[133:128], f[123:32]});
    f = cfg_flit(3'b001, 8'd62, 32'd7, 32'h0);
    cin_wr_data = f; cin_wr_data_wr = 1'b1;
    tick();
    cin_wr_data_wr = 1'b0;
    chk1("foreign_wr", cout_wr_data_wr, 1'b1);
    chkw("foreign_data", {10'd0, cout_wr_data}, {10'd0, f});

    // rst_n during capture aborts it
    cfg_write(32'd1, 32'd1);
    send(mkf(2'b01, 32'd300));
    chk1("abort_ram_wr", wr2ram_wr, 1'b1);
    send(mkf(2'b11, 32'd301));
    rst_n = 1'b0;
    #1;
    chk1("abort_bypass", pgm_bypass_flag, 1'b1);
    chk1("abort_ram_clr", wr2ram_wr, 1'b0);
    in_wr_data_wr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cfg_read("abort_tpl", 32'd5, 32'h0);
    cfg_read("abort_state", 32'd7, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
